dmem_responder: RTL

- Data-side responder for the single-cycle RV32I core. It is the target end of the core's memory interface: MemWrite, the ALUResult address, and WriteData come in; ReadData goes out.
- Contains a word-addressed data RAM and a small MMIO register block: a free-running 64-bit cycle counter, a tohost/exit register and a GPIO output register.
- Sits beside the core at SoC top level. It also provides the end-of-test signals used by the benches.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_responder_mmio_regs.sv | 55 +++++
 rtl/dmem_responder.sv | 87 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;

    // Word offsets inside the 16-byte MMIO window (ALUResult[3:2]).
    localparam logic [1:0] OFF_CYCLE_LO = 2'd0;
    localparam logic [1:0] OFF_CYCLE_HI = 2'd1;
    localparam logic [1:0] OFF_TOHOST   = 2'd2;
    localparam logic [1:0] OFF_GPIO     = 2'd3;

    // Which target an address falls into.
    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_MMIO     = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_e;

endpackage

// File: rtl/dmem_responder_mmio_regs.sv
// MMIO register block: 64-bit free-running cycle counter, TOHOST exit
// register and GPIO output register, plus their read mux.
module mmio_regs
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic [31:0] exit_code,
    output logic [31:0] gpio_out
);

    logic [63:0] count;

    // Counter runs every cycle; TOHOST is first-write-wins; CYCLE writes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 64'd0;
            done      <= 1'b0;
            exit_code <= 32'd0;
            gpio_out  <= 32'd0;
        end else begin
            count <= count + 64'd1;
            if (we) begin
                case (off)
                    OFF_TOHOST: begin
                        if (!done) begin
                            done      <= 1'b1;
                            exit_code <= wdata;
                        end
                    end
                    OFF_GPIO: gpio_out <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // Combinational register read; LO/HI are not captured atomically.
    always_comb begin
        rdata = 32'd0;
        case (off)
            OFF_CYCLE_LO: rdata = count[31:0];
            OFF_CYCLE_HI: rdata = count[63:32];
            OFF_TOHOST:   rdata = exit_code;
            OFF_GPIO:     rdata = gpio_out;
            default:      rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side responder for the single-cycle RV32I core: word RAM, MMIO
// registers, address decode, sticky access-error flag and zero-latency reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic [31:0] exit_code,
    output logic [31:0] gpio_out,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    region_e       region;
    logic          misaligned;
    logic [AW-1:0] word_idx;
    logic          ram_we;
    logic          mmio_we;
    logic          bad_write;
    logic [31:0]   mmio_rdata;
    logic [31:0]   mem [DEPTH_WORDS];

    assign misaligned = |ALUResult[1:0];
    assign word_idx   = ALUResult[AW+1:2];

    // Address decode: RAM occupies the bottom of the map, MMIO a 16-byte window.
    always_comb begin
        region = REG_UNMAPPED;
        if ((ALUResult >> (AW + 2)) == 32'd0)
            region = REG_RAM;
        else if (ALUResult[31:4] == MMIO_BASE[31:4])
            region = REG_MMIO;
    end

    // A misaligned store is dropped entirely, whatever region it targets.
    always_comb begin
        ram_we    = MemWrite && !misaligned && (region == REG_RAM);
        mmio_we   = MemWrite && !misaligned && (region == REG_MMIO);
        bad_write = MemWrite && (misaligned || (region == REG_UNMAPPED));
    end

    // RAM store; the array is never reset, but a store coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (ram_we && !rst)
            mem[word_idx] <= WriteData;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (bad_write)
            err <= 1'b1;
    end

    mmio_regs u_mmio (
        .clk       (clk),
        .rst       (rst),
        .we        (mmio_we),
        .off       (ALUResult[3:2]),
        .wdata     (WriteData),
        .rdata     (mmio_rdata),
        .done      (done),
        .exit_code (exit_code),
        .gpio_out  (gpio_out)
    );

    // Zero-latency read mux; unmapped addresses read as zero.
    always_comb begin
        ReadData = 32'd0;
        case (region)
            REG_RAM:  ReadData = mem[word_idx];
            REG_MMIO: ReadData = mmio_rdata;
            default:  ReadData = 32'd0;
        endcase
    end

endmodule
